// File: rtl/upcount_timer.sv
// Up-counting interval timer: counts 0..limit, then wraps (mode 0) or halts with done (mode 1).
// Parallel load, start/restart and registered tc/busy/done outputs.
module upcount_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;

    // busy_q mirrors (state_q == RUN) but is kept as its own flop so the output is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            tc_q    <= 1'b0;
        end else if (start) begin
            limit_q <= limit;
            mode_q  <= mode;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= RUN;
            busy_q  <= 1'b1;
        end else begin
            tc_q <= 1'b0;
            if (state_q == RUN && en) begin
                if (count_q == limit_q) begin
                    tc_q <= 1'b1;
                    if (mode_q) begin
                        done_q  <= 1'b1;
                        state_q <= HALT;
                        busy_q  <= 1'b0;
                    end else begin
                        count_q <= '0;
                    end
                end else begin
                    // Natural modulo wrap covers a load above limit_q.
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
